// File: rtl/lvds_word_framer.sv
// Per-lane word aligner for deserialised LVDS data: barrel-rotates each lane until the frame
// pattern (MSB=1, LSB=0) is seen C_LockCount times in a row. Define FRAMER_ERRCNT_EN for ErrCnt.
module lvds_word_framer #(
    parameter int C_Channels    = 2,
    parameter int C_WordWidth   = 12,
    parameter int C_LockCount   = 4,
    parameter int C_UnlockCount = 2
) (
    input  logic                                      RxClkDiv,
    input  logic                                      RxRst,
    input  logic                                      RxDataRdy,
    input  logic [C_Channels*C_WordWidth-1:0]         RxData,
    output logic [C_Channels*C_WordWidth-1:0]         RxDataOut,
    output logic                                      RxDataValid,
    output logic [C_Channels*$clog2(C_WordWidth)-1:0] RotAmount,
    output logic [C_Channels-1:0]                     ChLocked,
    output logic                                      AllLocked,
    output logic [C_Channels*16-1:0]                  ErrCnt
);

    localparam int            W         = C_WordWidth;
    localparam int            RW        = $clog2(C_WordWidth);
    localparam logic [RW-1:0] ROT_MAX   = RW'(W - 1);
    localparam logic [7:0]    GOOD_LAST = 8'(C_LockCount - 1);
    localparam logic [7:0]    BAD_LAST  = 8'(C_UnlockCount - 1);

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_t;

    state_t          state    [C_Channels];
    logic [RW-1:0]   rot      [C_Channels];
    logic [7:0]      good_cnt [C_Channels];
    logic [7:0]      bad_cnt  [C_Channels];
    logic [W-1:0]    rot_word [C_Channels];
    logic [C_Channels-1:0] good;
    logic [2*W-1:0]  dbl;

    function automatic logic [RW-1:0] next_rot(input logic [RW-1:0] r);
        return (r == ROT_MAX) ? '0 : r + RW'(1);
    endfunction

    // Upper half of {raw,raw} << rot is the circular left rotation of raw by rot.
    always_comb begin
        dbl      = '0;
        good     = '0;
        rot_word = '{default: '0};
        for (int n = 0; n < C_Channels; n++) begin
            dbl         = {RxData[n*W +: W], RxData[n*W +: W]} << rot[n];
            rot_word[n] = dbl[2*W-1:W];
            good[n]     = rot_word[n][W-1] & ~rot_word[n][0];
        end
    end

    always_comb begin
        RotAmount = '0;
        for (int n = 0; n < C_Channels; n++) begin
            RotAmount[n*RW +: RW] = rot[n];
        end
    end

    assign AllLocked = &ChLocked;

    always_ff @(posedge RxClkDiv) begin
        if (RxRst) begin
            RxDataValid <= 1'b0;
            RxDataOut   <= '0;
            ChLocked    <= '0;
            for (int n = 0; n < C_Channels; n++) begin
                state[n]    <= HUNT;
                rot[n]      <= '0;
                good_cnt[n] <= '0;
                bad_cnt[n]  <= '0;
            end
        end else begin
            RxDataValid <= RxDataRdy;
            if (RxDataRdy) begin
                for (int n = 0; n < C_Channels; n++) begin
                    RxDataOut[n*W +: W] <= rot_word[n];
                    case (state[n])
                        HUNT: begin
                            if (good[n]) begin
                                state[n]    <= CHECK;
                                good_cnt[n] <= 8'd1;
                            end else begin
                                rot[n] <= next_rot(rot[n]);
                            end
                        end
                        CHECK: begin
                            if (good[n]) begin
                                if (good_cnt[n] == GOOD_LAST) begin
                                    state[n]    <= LOCKED;
                                    ChLocked[n] <= 1'b1;
                                    good_cnt[n] <= '0;
                                end else begin
                                    good_cnt[n] <= good_cnt[n] + 8'd1;
                                end
                            end else begin
                                state[n]    <= HUNT;
                                rot[n]      <= next_rot(rot[n]);
                                good_cnt[n] <= '0;
                            end
                        end
                        LOCKED: begin
                            if (good[n]) begin
                                bad_cnt[n] <= '0;
                            end else if (bad_cnt[n] == BAD_LAST) begin
                                state[n]    <= HUNT;
                                ChLocked[n] <= 1'b0;
                                rot[n]      <= next_rot(rot[n]);
                                bad_cnt[n]  <= '0;
                            end else begin
                                bad_cnt[n] <= bad_cnt[n] + 8'd1;
                            end
                        end
                        default: begin
                            state[n]    <= HUNT;
                            ChLocked[n] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef FRAMER_ERRCNT_EN
    // Counts every bad word seen while locked, including the one that drops lock.
    always_ff @(posedge RxClkDiv) begin
        if (RxRst) begin
            ErrCnt <= '0;
        end else if (RxDataRdy) begin
            for (int n = 0; n < C_Channels; n++) begin
                if (state[n] == LOCKED && !good[n] && ErrCnt[n*16 +: 16] != 16'hFFFF) begin
                    ErrCnt[n*16 +: 16] <= ErrCnt[n*16 +: 16] + 16'd1;
                end
            end
        end
    end
`else
    assign ErrCnt = '0;
`endif

endmodule

// File: tb/tb_lvds_word_framer.sv
// Randomised and directed bench for lvds_word_framer against a lock/rotation model.
// Honours FRAMER_ERRCNT_EN the same way as the design.
module tb_lvds_word_framer;

    localparam int CH     = 2;
    localparam int W      = 12;
    localparam int RW     = 4;
    localparam int LOCK   = 4;
    localparam int UNLOCK = 2;
`ifdef FRAMER_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              RxClkDiv = 1'b0;
    logic              RxRst;
    logic              RxDataRdy;
    logic [CH*W-1:0]   RxData;
    logic [CH*W-1:0]   RxDataOut;
    logic              RxDataValid;
    logic [CH*RW-1:0]  RotAmount;
    logic [CH-1:0]     ChLocked;
    logic              AllLocked;
    logic [CH*16-1:0]  ErrCnt;

    lvds_word_framer #(
        .C_Channels   (CH),
        .C_WordWidth  (W),
        .C_LockCount  (LOCK),
        .C_UnlockCount(UNLOCK)
    ) dut (
        .RxClkDiv   (RxClkDiv),
        .RxRst      (RxRst),
        .RxDataRdy  (RxDataRdy),
        .RxData     (RxData),
        .RxDataOut  (RxDataOut),
        .RxDataValid(RxDataValid),
        .RotAmount  (RotAmount),
        .ChLocked   (ChLocked),
        .AllLocked  (AllLocked),
        .ErrCnt     (ErrCnt)
    );

    always #5 RxClkDiv = ~RxClkDiv;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: while unlocked, a run of LOCK good words locks; any bad word rotates and restarts.
    int m_rot    [CH];
    int m_locked [CH];
    int m_run    [CH];
    int m_err    [CH];
    int m_data   [CH];
    int m_valid;

    function automatic int rotw(input int raw, input int r);
        return ((raw << r) | (raw >> (W - r))) & 'hFFF;
    endfunction

    task automatic compareValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input logic rst, input logic rdy, input logic [CH*W-1:0] data);
        int w;
        bit ok;
        if (rst) begin
            m_valid = 0;
            for (int l = 0; l < CH; l++) begin
                m_rot[l] = 0; m_locked[l] = 0; m_run[l] = 0; m_err[l] = 0; m_data[l] = 0;
            end
        end else begin
            m_valid = rdy ? 1 : 0;
            if (rdy) begin
                for (int l = 0; l < CH; l++) begin
                    w         = rotw(int'(data[l*W +: W]), m_rot[l]);
                    m_data[l] = w;
                    ok        = (((w >> (W - 1)) & 1) == 1) && ((w & 1) == 0);
                    if (m_locked[l] == 0) begin
                        if (ok) begin
                            m_run[l]++;
                            if (m_run[l] == LOCK) begin
                                m_locked[l] = 1;
                                m_run[l]    = 0;
                            end
                        end else begin
                            m_rot[l] = (m_rot[l] + 1) % W;
                            m_run[l] = 0;
                        end
                    end else if (ok) begin
                        m_run[l] = 0;
                    end else begin
                        if (m_err[l] < 65535) m_err[l]++;
                        m_run[l]++;
                        if (m_run[l] == UNLOCK) begin
                            m_locked[l] = 0;
                            m_run[l]    = 0;
                            m_rot[l]    = (m_rot[l] + 1) % W;
                        end
                    end
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic [CH*W-1:0]  e_out;
        logic [CH*RW-1:0] e_rot;
        logic [CH-1:0]    e_lk;
        logic [CH*16-1:0] e_err;
        for (int l = 0; l < CH; l++) begin
            e_out[l*W +: W]   = W'(m_data[l]);
            e_rot[l*RW +: RW] = RW'(m_rot[l]);
            e_lk[l]           = (m_locked[l] != 0);
            e_err[l*16 +: 16] = ERR_EN ? 16'(m_err[l]) : 16'd0;
        end
        compareValue("valid",     {63'd0, RxDataValid}, 64'(m_valid));
        compareValue("data_out",  64'(RxDataOut), 64'(e_out));
        compareValue("rot",       64'(RotAmount), 64'(e_rot));
        compareValue("ch_locked", 64'(ChLocked),  64'(e_lk));
        compareValue("all_lock",  {63'd0, AllLocked}, {63'd0, &e_lk});
        compareValue("err_cnt",   64'(ErrCnt), 64'(e_err));
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy, input logic [CH*W-1:0] data);
        RxRst     = rst;
        RxDataRdy = rdy;
        RxData    = data;
        modelStep(rst, rdy, data);
        @(posedge RxClkDiv);
        #1;
        checkOutput();
    endtask

    task automatic strobe(input int l0, input int l1);
        applyStimulus(1'b0, 1'b1, {12'(l1), 12'(l0)});
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0);
    endtask

    initial begin
        int tgt  [CH];
        int life [CH];
        int g;
        logic [CH*W-1:0] rnd;

        RxRst = 1'b1; RxDataRdy = 1'b0; RxData = '0;
        doReset();
        compareValue("rst_out",   64'(RxDataOut), 64'd0);
        compareValue("rst_valid", {63'd0, RxDataValid}, 64'd0);
        compareValue("rst_rot",   64'(RotAmount), 64'd0);
        compareValue("rst_lock",  64'(ChLocked), 64'd0);
        compareValue("rst_err",   64'(ErrCnt), 64'd0);

        // Lane 0 needs rot 3, lane 1 needs rot 5.
        for (int i = 1; i <= 9; i++) begin
            strobe('h100, 'h040);
            if (i == 3) compareValue("rot0_after3", 64'(RotAmount[3:0]), 64'd3);
            if (i == 6) compareValue("lock0_at6", 64'(ChLocked), 64'd0);
            if (i == 7) begin
                compareValue("lock_at7", 64'(ChLocked), 64'b01);
                compareValue("out0_at7", 64'(RxDataOut[11:0]), 64'h800);
                compareValue("all_at7",  {63'd0, AllLocked}, 64'd0);
            end
            if (i == 8) compareValue("all_at8", {63'd0, AllLocked}, 64'd0);
        end
        compareValue("lock_at9", 64'(ChLocked), 64'b11);
        compareValue("all_at9",  {63'd0, AllLocked}, 64'd1);
        compareValue("rot_at9",  64'(RotAmount), 64'h53);
        compareValue("out_at9",  64'(RxDataOut), 64'h800800);

        // Single bad word while locked, then good.
        strobe('h001, 'h040);
        compareValue("one_bad_lock", 64'(ChLocked), 64'b11);
        strobe('h100, 'h040);
        compareValue("one_bad_lock2", 64'(ChLocked), 64'b11);
        compareValue("one_bad_err",   64'(ErrCnt[15:0]), ERR_EN ? 64'd1 : 64'd0);

        // Two consecutive bad words from a fresh lock.
        doReset();
        repeat (9) strobe('h100, 'h040);
        strobe('h001, 'h040);
        compareValue("bad1_lock", 64'(ChLocked), 64'b11);
        strobe('h001, 'h040);
        compareValue("bad2_lock", 64'(ChLocked), 64'b10);
        compareValue("bad2_rot0", 64'(RotAmount[3:0]), 64'd4);
        compareValue("bad2_rot1", 64'(RotAmount[7:4]), 64'd5);
        compareValue("bad2_err0", 64'(ErrCnt[15:0]), ERR_EN ? 64'd2 : 64'd0);
        compareValue("bad2_err1", 64'(ErrCnt[31:16]), 64'd0);

        // Bad word in CHECK after two good words, with idle gaps between strobes.
        doReset();
        for (int i = 0; i < 5; i++) begin
            strobe('h100, 'h000);
            applyStimulus(1'b0, 1'b0, RxData);
        end
        strobe('h001, 'h000);
        compareValue("check_rot0", 64'(RotAmount[3:0]), 64'd4);
        compareValue("check_lock", 64'(ChLocked), 64'd0);

        // Reset coinciding with a strobe while locked.
        doReset();
        repeat (9) strobe('h100, 'h040);
        applyStimulus(1'b1, 1'b1, {12'h040, 12'h100});
        compareValue("rr_out",   64'(RxDataOut), 64'd0);
        compareValue("rr_valid", {63'd0, RxDataValid}, 64'd0);
        compareValue("rr_rot",   64'(RotAmount), 64'd0);
        compareValue("rr_lock",  64'(ChLocked), 64'd0);
        compareValue("rr_all",   {63'd0, AllLocked}, 64'd0);
        applyStimulus(1'b0, 1'b0, '0);

        // Random traffic: each lane drifts between target rotations, with noise, gaps, resets.
        for (int l = 0; l < CH; l++) life[l] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < CH; l++) begin
                if (life[l] == 0) begin
                    tgt[l]  = int'($urandom_range(0, W - 1));
                    life[l] = int'($urandom_range(20, 60));
                end
                life[l]--;
                g = 'h800 | int'($urandom & 'h7FE);
                if ($urandom_range(0, 9) == 0) rnd[l*W +: W] = W'($urandom);
                else                           rnd[l*W +: W] = W'(rotw(g, (W - tgt[l]) % W));
            end
            applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0, rnd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvds_word_framer.md
LVDS_WORD_FRAMER -- requirements
Module: lvds_word_framer

Interface
REQ-001 SHALL have parameter C_Channels, default 2, number of independent deserialised LVDS lanes (1..8).
REQ-002 SHALL have parameter C_WordWidth, default 12, bits per lane word (4..16).
REQ-003 SHALL have parameter C_LockCount, default 4, consecutive good words to declare lock (2..255).
REQ-004 SHALL have parameter C_UnlockCount, default 2, consecutive bad words in LOCKED to drop lock (1..255).
REQ-005 SHALL have port RxClkDiv  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port RxRst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port RxDataRdy  input  1  one-cycle strobe qualifying RxData for all lanes.
REQ-008 SHALL have port RxData  input  C_Channels*C_WordWidth  raw lane words; lane n at bits [n*W+W-1 : n*W].
REQ-009 SHALL have port RxDataOut  output  C_Channels*C_WordWidth  rotated (aligned) words, same packing.
REQ-010 SHALL have port RxDataValid  output  1  qualifies RxDataOut.
REQ-011 SHALL have port RotAmount  output  C_Channels*clog2(C_WordWidth)  current rotation per lane.
REQ-012 SHALL have port ChLocked  output  C_Channels  per-lane lock flag.
REQ-013 SHALL have port AllLocked  output  1  AND of ChLocked.
REQ-014 SHALL have port ErrCnt  output  C_Channels*16  per-lane framing-error count.

Function
REQ-015 Rotation SHALL be rot_word = ((raw << rot) | (raw >> (W-rot))) truncated to W bits; rot=0 passes raw unchanged.
REQ-016 Framing good SHALL mean rot_word[W-1]==1 and rot_word[0]==0, evaluated with rot as held before the strobe.
REQ-017 Each lane SHALL run an FSM with states HUNT, CHECK, LOCKED; state changes only on cycles with RxDataRdy=1.
REQ-018 HUNT: good word -> CHECK with good_cnt=1; bad word -> stay, rot increments, wrapping W-1 -> 0.
REQ-019 CHECK: good word -> good_cnt+1; reaching C_LockCount -> LOCKED; bad word -> HUNT, rot increments with wrap, good_cnt=0.
REQ-020 LOCKED: good word clears bad_cnt; bad word increments bad_cnt; reaching C_UnlockCount -> HUNT, rot increments with wrap, bad_cnt=0.
REQ-021 rot SHALL change only on the HUNT/CHECK/LOCKED bad-word transitions above; new rot applies from the next strobe.
REQ-022 RxDataOut and RxDataValid SHALL be registered: RxDataValid=1 exactly one cycle after each RxDataRdy, RxDataOut = rot_word of that strobe; RxDataOut holds between strobes.
REQ-023 ChLocked[n] SHALL be 1 exactly while lane n is in LOCKED, registered with the FSM (same cycle as RxDataValid).
REQ-024 Back-to-back strobes (RxDataRdy high on consecutive cycles) SHALL be processed without loss.
REQ-025 Lanes SHALL be fully independent; one lane losing lock SHALL NOT alter another lane's state, rot or counters.

Reset
REQ-026 RxRst=1 SHALL, on the next edge, force all FSMs to HUNT, rot=0, good_cnt=bad_cnt=0, RxDataOut=0, RxDataValid=0, ChLocked=0, AllLocked=0, ErrCnt=0.
REQ-027 RxRst SHALL take priority over a simultaneous RxDataRdy; the word on that cycle is discarded.
REQ-028 Reset mid-operation (any state) SHALL produce the same result as power-on reset.

Configuration
REQ-029 Macro FRAMER_ERRCNT_EN defined: each lane's ErrCnt SHALL increment by 1 per bad word received in LOCKED (including the word causing unlock), saturating at 16'hFFFF, cleared only by RxRst.
REQ-030 FRAMER_ERRCNT_EN undefined: ErrCnt SHALL be constant 0 and no counter logic SHALL be synthesised; all other behaviour identical.

Verification
REQ-031 W=12, C_LockCount=4, lane0 strobes 0x100 continuously -> words 1-3 bad (rot 0,1,2), rot=3 from word 4; ChLocked[0]=1 one cycle after 7th strobe; RxDataOut lane0=0x800.
REQ-032 Lanes 0/1 fed 0x100/0x040 -> RotAmount 3/5, AllLocked=1 only after both ChLocked high; each RxDataOut=0x800.
REQ-033 Locked lane, C_UnlockCount=2, inject one bad word (0x001) then good -> stays LOCKED, ErrCnt=1 (macro on); two consecutive bad -> HUNT, ChLocked=0, rot=4, ErrCnt=2.
REQ-034 In CHECK after 2 good words, inject bad -> HUNT, rot increments, ChLocked never asserted.
REQ-035 Assert RxRst together with RxDataRdy while LOCKED -> next cycle all outputs 0, RxDataValid=0, RotAmount=0.
REQ-036 Macro undefined, repeat REQ-033 -> ErrCnt remains 0, lock behaviour unchanged.
